// File: rtl/reg_free_list.sv
// Circular free list of physical register indices between commit and rename.
// Rename pops the index at the head; commit pushes released indices at the tail.
// Optional duplicate-return checking is compiled in with FREE_LIST_DUP_CHECK_EN.
//
// Ports:
//   clk           clock, all state on rising edge
//   n_rst         asynchronous active-low reset
//   alloc_req     rename requests one free index this cycle
//   alloc_valid   a free index is available (registered)
//   alloc_addr    index at head, meaningful only with alloc_valid (registered)
//   ret_valid     commit returns an index this cycle
//   ret_addr      index being returned
//   free_count    number of indices currently held (registered)
//   empty         free_count == 0 (registered)
//   overflow_err  sticky: a return arrived while full and was dropped
//   dup_err       sticky: duplicate/out-of-range return (0 without the macro)
module reg_free_list #(
  parameter  int unsigned PHYS_REGS = 32,
  parameter  int unsigned ARCH_REGS = 16,
  localparam int unsigned AW        = $clog2(PHYS_REGS)
) (
  input  logic          clk,
  input  logic          n_rst,
  input  logic          alloc_req,
  output logic          alloc_valid,
  output logic [AW-1:0] alloc_addr,
  input  logic          ret_valid,
  input  logic [AW-1:0] ret_addr,
  output logic [AW:0]   free_count,
  output logic          empty,
  output logic          overflow_err,
  output logic          dup_err
);

  localparam int unsigned DEPTH = PHYS_REGS - ARCH_REGS;
  localparam int unsigned PW    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CW    = AW + 1;

  // Pointers wrap at DEPTH-1, so DEPTH need not be a power of two.
  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
  endfunction

  logic [AW-1:0] entry_q [DEPTH];
  logic [PW-1:0] head_q, head_n;
  logic [PW-1:0] tail_q, tail_n;
  logic [CW-1:0] count_q, count_n;
  logic [AW-1:0] alloc_addr_q, alloc_addr_n;
  logic          alloc_valid_q, empty_q, overflow_q;
  logic          alloc_fire, ret_fire, ret_dup, full;

  // Next-state for pointers, count and the registered head view.
  always_comb begin
    alloc_fire   = alloc_req & alloc_valid_q;
    full         = (count_q == CW'(DEPTH));
    ret_fire     = ret_valid & ~ret_dup & (~full | alloc_fire);
    head_n       = head_q;
    tail_n       = tail_q;
    count_n      = count_q;
    if (alloc_fire) head_n = ptr_inc(head_q);
    if (ret_fire)   tail_n = ptr_inc(tail_q);
    if (ret_fire && !alloc_fire)      count_n = count_q + CW'(1);
    else if (alloc_fire && !ret_fire) count_n = count_q - CW'(1);
    // Head view after the edge: a write landing on the new head wins.
    if (ret_fire && (tail_q == head_n)) alloc_addr_n = ret_addr;
    else                                alloc_addr_n = entry_q[head_n];
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      for (int i = 0; i < int'(DEPTH); i++) entry_q[i] <= AW'(ARCH_REGS + i);
      head_q        <= '0;
      tail_q        <= '0;
      count_q       <= CW'(DEPTH);
      alloc_addr_q  <= AW'(ARCH_REGS);
      alloc_valid_q <= (DEPTH != 0);
      empty_q       <= (DEPTH == 0);
      overflow_q    <= 1'b0;
    end else begin
      if (ret_fire) entry_q[tail_q] <= ret_addr;
      head_q        <= head_n;
      tail_q        <= tail_n;
      count_q       <= count_n;
      alloc_addr_q  <= alloc_addr_n;
      alloc_valid_q <= (count_n != '0);
      empty_q       <= (count_n == '0);
      if (ret_valid && !ret_dup && full && !alloc_fire) overflow_q <= 1'b1;
    end
  end

`ifdef FREE_LIST_DUP_CHECK_EN
  logic [PHYS_REGS-1:0] bitmap_q, bitmap_n;
  logic                 dup_err_q;
  logic                 ret_oor;

  // A return is a duplicate if already free, unless it is the index leaving this cycle.
  always_comb begin
    ret_oor = ({1'b0, ret_addr} >= CW'(PHYS_REGS));
    ret_dup = ret_oor ||
              (bitmap_q[ret_addr] && !(alloc_fire && (alloc_addr_q == ret_addr)));
    bitmap_n = bitmap_q;
    if (alloc_fire) bitmap_n[alloc_addr_q] = 1'b0;
    if (ret_fire)   bitmap_n[ret_addr]     = 1'b1;
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      for (int i = 0; i < int'(PHYS_REGS); i++) bitmap_q[i] <= (i >= int'(ARCH_REGS));
      dup_err_q <= 1'b0;
    end else begin
      bitmap_q <= bitmap_n;
      if (ret_valid && ret_dup) dup_err_q <= 1'b1;
    end
  end

  assign dup_err = dup_err_q;
`else
  assign ret_dup = 1'b0;
  assign dup_err = 1'b0;
`endif

  assign alloc_valid  = alloc_valid_q;
  assign alloc_addr   = alloc_addr_q;
  assign free_count   = count_q;
  assign empty        = empty_q;
  assign overflow_err = overflow_q;

endmodule

// File: tb/tb_reg_free_list.sv
// Directed bench for reg_free_list with default parameters (32 phys, 16 arch).
module tb_reg_free_list;

  logic       clk = 1'b0;
  logic       n_rst;
  logic       alloc_req;
  logic       alloc_valid;
  logic [4:0] alloc_addr;
  logic       ret_valid;
  logic [4:0] ret_addr;
  logic [5:0] free_count;
  logic       empty;
  logic       overflow_err;
  logic       dup_err;

  int vectors    = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  reg_free_list dut (
    .clk          (clk),
    .n_rst        (n_rst),
    .alloc_req    (alloc_req),
    .alloc_valid  (alloc_valid),
    .alloc_addr   (alloc_addr),
    .ret_valid    (ret_valid),
    .ret_addr     (ret_addr),
    .free_count   (free_count),
    .empty        (empty),
    .overflow_err (overflow_err),
    .dup_err      (dup_err)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic a, input logic r, input logic [4:0] ra);
    alloc_req = a;
    ret_valid = r;
    ret_addr  = ra;
  endtask

  initial begin
    logic [4:0] q[$];
    logic [4:0] e;

    n_rst = 1'b1;
    drive(1'b0, 1'b0, 5'd0);
    #2 n_rst = 1'b0;
    #1;
    chk("rst_valid",    32'(alloc_valid),  32'd1);
    chk("rst_addr",     32'(alloc_addr),   32'd16);
    chk("rst_count",    32'(free_count),   32'd16);
    chk("rst_empty",    32'(empty),        32'd0);
    chk("rst_overflow", 32'(overflow_err), 32'd0);
    chk("rst_dup",      32'(dup_err),      32'd0);
    tick();
    tick();
    n_rst = 1'b1;
    tick();

    // Drain all 16 free indices back to back.
    for (int i = 0; i < 16; i++) begin
      chk("drain_addr",  32'(alloc_addr),  32'(16 + i));
      chk("drain_valid", 32'(alloc_valid), 32'd1);
      drive(1'b1, 1'b0, 5'd0);
      tick();
    end
    chk("drained_empty", 32'(empty),       32'd1);
    chk("drained_valid", 32'(alloc_valid), 32'd0);
    chk("drained_count", 32'(free_count),  32'd0);
    tick();  // 17th request while empty
    chk("req_empty_count", 32'(free_count), 32'd0);
    chk("req_empty_empty", 32'(empty),      32'd1);

    // Return 5 together with a request while empty: no bypass.
    drive(1'b1, 1'b1, 5'd5);
    chk("bypass_valid", 32'(alloc_valid), 32'd0);
    tick();
    drive(1'b0, 1'b0, 5'd0);
    chk("ret5_addr",  32'(alloc_addr),  32'd5);
    chk("ret5_count", 32'(free_count),  32'd1);
    chk("ret5_valid", 32'(alloc_valid), 32'd1);

    // Refill to full with 16..30; list order is 5,16..30.
    for (int i = 16; i <= 30; i++) begin
      drive(1'b0, 1'b1, 5'(i));
      tick();
    end
    drive(1'b0, 1'b0, 5'd0);
    chk("full_count", 32'(free_count), 32'd16);

    // Return while full with no alloc: dropped, sticky overflow.
    drive(1'b0, 1'b1, 5'd9);
    tick();
    drive(1'b0, 1'b0, 5'd0);
    chk("ovf_err",   32'(overflow_err), 32'd1);
    chk("ovf_count", 32'(free_count),   32'd16);
    chk("ovf_addr",  32'(alloc_addr),   32'd5);

    // Alloc + return while full: both accepted.
    drive(1'b1, 1'b1, 5'd9);
    tick();
    drive(1'b0, 1'b0, 5'd0);
    chk("full_both_count", 32'(free_count), 32'd16);
    chk("full_both_addr",  32'(alloc_addr), 32'd16);

    // Drain 16..30; 9 must then be at the head.
    for (int i = 16; i <= 30; i++) begin
      chk("redrain_addr", 32'(alloc_addr), 32'(i));
      drive(1'b1, 1'b0, 5'd0);
      tick();
    end
    drive(1'b0, 1'b0, 5'd0);
    chk("tail_addr",  32'(alloc_addr), 32'd9);
    chk("tail_count", 32'(free_count), 32'd1);
    chk("ovf_sticky", 32'(overflow_err), 32'd1);

    // Empty the list, then load 20,21,22.
    drive(1'b1, 1'b0, 5'd0);
    tick();
    for (int i = 20; i <= 22; i++) begin
      drive(1'b0, 1'b1, 5'(i));
      tick();
      q.push_back(5'(i));
    end
    drive(1'b0, 1'b0, 5'd0);
    chk("load_count", 32'(free_count), 32'd3);

    // Recirculate the head for 40 cycles: pointers wrap, order and count hold.
    for (int i = 0; i < 40; i++) begin
      e = q.pop_front();
      chk("wrap_addr", 32'(alloc_addr), 32'(e));
      drive(1'b1, 1'b1, e);
      tick();
      q.push_back(e);
      chk("wrap_count", 32'(free_count), 32'd3);
    end
    drive(1'b0, 1'b0, 5'd0);
    chk("wrap_final_addr", 32'(alloc_addr), 32'(q[0]));

    // Return 20 while it is already free.
    drive(1'b0, 1'b1, 5'd20);
    tick();
    drive(1'b0, 1'b0, 5'd0);
`ifdef FREE_LIST_DUP_CHECK_EN
    chk("dup_err",   32'(dup_err),    32'd1);
    chk("dup_count", 32'(free_count), 32'd3);
`else
    chk("dup_err",   32'(dup_err),    32'd0);
    chk("dup_count", 32'(free_count), 32'd4);
`endif

    // Asynchronous reset mid-cycle restores the reset image without a clock edge.
    #2 n_rst = 1'b0;
    #1;
    chk("arst_count",    32'(free_count),   32'd16);
    chk("arst_addr",     32'(alloc_addr),   32'd16);
    chk("arst_valid",    32'(alloc_valid),  32'd1);
    chk("arst_overflow", 32'(overflow_err), 32'd0);
    chk("arst_dup",      32'(dup_err),      32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
